fft_twiddle_fetch: RTL and testbench
====================================

// Module: fft_twiddle_fetch
// PURPOSE
//  Read-side sequencer for the twiddle ROM pair (real / imaginary images, 5-bit addr, 16-bit Q8.8, 1-cycle registered read).
//  On start it walks a contiguous ROM range, absorbs the ROM read latency and streams {re,im} pairs to the butterfly datapath.
//  The output uses a valid/ready handshake, with a 2-entry buffer so that backpressure never drops a word.
//  Sits between the FFT stage controller (start/base/length) and the butterfly multiplier.
// PARAMETERS
//  AW         5   ROM address width
//  DW         16  twiddle word width (Q8.8 two's complement, 0x0100 = +1.0)
//  ROM_DEPTH  28  number of valid ROM entries; address generation wraps modulo this value
// PORTS
//  clk          in   1      single clock; all logic on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  start        in   1      1-cycle request; sampled only in IDLE
//  base_addr    in   AW     first ROM address of the range (captured on start)
//  length       in   AW+1   number of twiddle pairs to fetch, 0..ROM_DEPTH (captured on start)
//  busy         out  1      high from the accepted start until done
//  done         out  1      1-cycle pulse after the final output handshake
//  rom_addr     out  AW     address to both ROM images (registered)
//  rom_re_data  in   DW     real ROM output, valid 1 cycle after rom_addr
//  rom_im_data  in   DW     imaginary ROM output, valid 1 cycle after rom_addr
//  tw_valid     out  1      output pair valid
//  tw_ready     in   1      downstream accept
//  tw_re        out  DW     real twiddle
//  tw_im        out  DW     imaginary twiddle (passed through unmodified, sign as stored)
//  tw_index     out  AW+1   0-based position of this pair within the current range
//  tw_last      out  1      high with the final pair of the range
// BEHAVIOUR
//  Reset values (rst_n=0 at an edge): busy=0, done=0, rom_addr=0, tw_valid=0, tw_re/tw_im/tw_index=0, tw_last=0.
//    Buffer and counters are cleared and FSM = IDLE.
//  Reset mid-operation aborts the range: buffered words are discarded and no done pulse is produced.
//  FSM states:
//    IDLE:  start=1 -> capture base/length, busy=1.
//           length=0 -> DONE; otherwise -> RUN.
//    RUN:   issue addresses; when all length addresses are issued -> DRAIN.
//    DRAIN: wait until the in-flight read and the buffer are empty and the last handshake completes -> DONE.
//    DONE:  done=1 for one cycle, busy=0 -> IDLE.
//  Issue rule: a new address is driven in a cycle only if pending + buf_count + (issue this cycle) <= 2.
//    pending = an address issued last cycle whose data lands this cycle.
//  Capture rule: when pending=1, {rom_re_data, rom_im_data, index, last} is written into the 2-entry FIFO this cycle.
//    No ROM enable exists; rom_addr is held when not issuing.
//  Address sequence: base, base+1, ... modulo ROM_DEPTH (e.g. base=26, len=4 -> 26, 27, 0, 1).
//  Output: tw_valid = FIFO non-empty; a pop occurs on tw_valid & tw_ready.
//    Output signals stay stable while tw_valid=1 and tw_ready=0.
//  Latency: with tw_ready held at 1, the first pair is valid 2 cycles after the start edge, then one pair per cycle.
//    Throughput is 1/cycle under sustained ready.
//  Simultaneous push and pop on a full or empty FIFO are both legal; the count is unchanged.
//  start while busy=1 is ignored and does not corrupt the range.
//  done is asserted the cycle after the tw_last handshake; a new start is accepted no earlier than the cycle after done.
//  length > ROM_DEPTH is clamped to ROM_DEPTH; base_addr >= ROM_DEPTH is reduced modulo ROM_DEPTH.
// STRUCTURE
//  Shared package fft_twiddle_pkg:
//    TW_AW, TW_DW, TW_ROM_DEPTH constants
//    tw_state_t enum {IDLE, RUN, DRAIN, DONE}
//    tw_word_t struct {re, im, index, last}
//  Sub-module tw_skid_fifo: 2-entry synchronous FIFO of tw_word_t with push/pop/count.
//    The top level holds the FSM, the address counter with modulo wrap, and the issue-credit logic.
// TESTING
//  1 Streaming: base=4, len=8, tw_ready=1.
//    -> rom_addr 4..11; tw_im = 0000, FF00, 0000, FF00, 0000, FF4A, FF00, FF4A.
//    -> tw_index 0..7; tw_last on index 7; done one cycle later.
//  2 Backpressure: base=16, len=12, tw_ready toggled randomly.
//    -> all 12 pairs delivered in order with no loss or duplication (im FF00 ... FF7C).
//    -> outputs stable while stalled; at most 2 reads outstanding.
//  3 Wrap: base=26, len=4.
//    -> addresses 26, 27, 0, 1; tw_im = FF87, FF7C, 0000, 0000; tw_last on the 4th pair.
//  4 Edge lengths: len=0 -> done 1 cycle after start with tw_valid never high.
//    len=31 -> clamped to 28 pairs.
//  5 Reset mid-run: rst_n=0 for one cycle after 3 of 8 pairs.
//    -> all outputs 0 next cycle, no done; a new start with base=0, len=2 is then served correctly.
//  6 start while busy: a pulse with base=9 during a base=0, len=6 range is ignored.
//    -> only addresses 0..5 are fetched.

Source files
------------

// File: rtl/fft_twiddle_pkg.sv
// Shared constants and types for the twiddle ROM read sequencer.
package fft_twiddle_pkg;

  localparam int unsigned TW_AW        = 5;
  localparam int unsigned TW_DW        = 16;
  localparam int unsigned TW_ROM_DEPTH = 28;

  localparam logic [TW_AW:0]   TW_LEN_MAX   = (TW_AW + 1)'(TW_ROM_DEPTH);
  localparam logic [TW_AW-1:0] TW_DEPTH_A   = TW_AW'(TW_ROM_DEPTH);
  localparam logic [TW_AW-1:0] TW_ADDR_LAST = TW_AW'(TW_ROM_DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } tw_state_t;

  typedef struct packed {
    logic [TW_DW-1:0] re;
    logic [TW_DW-1:0] im;
    logic [TW_AW:0]   index;
    logic             last;
  } tw_word_t;

  // Next ROM address, wrapping at the last valid entry rather than at 2**TW_AW.
  function automatic logic [TW_AW-1:0] tw_addr_inc(input logic [TW_AW-1:0] addr);
    return (addr == TW_ADDR_LAST) ? '0 : addr + 1'b1;
  endfunction

endpackage

// File: rtl/fft_twiddle_fetch_if.sv
// Twiddle output stream towards the butterfly multiplier (valid/ready).
interface fft_twiddle_fetch_if;
  import fft_twiddle_pkg::*;

  logic             tw_valid;
  logic             tw_ready;
  logic [TW_DW-1:0] tw_re;
  logic [TW_DW-1:0] tw_im;
  logic [TW_AW:0]   tw_index;
  logic             tw_last;

  modport master (
    output tw_valid,
    output tw_re,
    output tw_im,
    output tw_index,
    output tw_last,
    input  tw_ready
  );

  modport slave (
    input  tw_valid,
    input  tw_re,
    input  tw_im,
    input  tw_index,
    input  tw_last,
    output tw_ready
  );

endinterface

// File: rtl/tw_skid_fifo.sv
// Two-entry synchronous FIFO of twiddle words; caller guarantees no overflow/underflow.
module tw_skid_fifo
  import fft_twiddle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  tw_word_t   wdata,
  input  logic       pop,
  output tw_word_t   rdata,
  output logic [1:0] count
);

  tw_word_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fft_twiddle_fetch.sv
// Walks a contiguous twiddle ROM range and streams {re,im} pairs through a 2-entry buffer.
module fft_twiddle_fetch
  import fft_twiddle_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [TW_AW-1:0]   base_addr,
  input  logic [TW_AW:0]     length,
  output logic               busy,
  output logic               done,
  output logic [TW_AW-1:0]   rom_addr,
  input  logic [TW_DW-1:0]   rom_re_data,
  input  logic [TW_DW-1:0]   rom_im_data,
  fft_twiddle_fetch_if.master tw
);

  tw_state_t        state_q, state_d;
  logic [TW_AW:0]   len_q;
  logic [TW_AW:0]   issued_q;
  logic [TW_AW-1:0] next_addr_q;
  logic [TW_AW-1:0] rom_addr_q;
  logic             pending_q;
  logic [TW_AW:0]   pend_index_q;
  logic             pend_last_q;

  logic [TW_AW:0]   len_clamp;
  logic [TW_AW-1:0] base_mod;
  logic             fifo_valid;
  logic             pop;
  logic             issue;
  logic [1:0]       count_eff;
  logic [2:0]       credit_used;
  tw_word_t         fifo_wdata;
  tw_word_t         fifo_rdata;
  logic [1:0]       fifo_count;

  always_comb begin
    len_clamp   = (length > TW_LEN_MAX) ? TW_LEN_MAX : length;
    base_mod    = (base_addr >= TW_DEPTH_A) ? base_addr - TW_DEPTH_A : base_addr;
    fifo_valid  = (fifo_count != 2'd0);
    pop         = fifo_valid && tw.tw_ready;
    // Occupancy after this cycle's pop plus the word landing now; one more issue must still fit.
    count_eff   = fifo_count - {1'b0, pop};
    credit_used = {1'b0, count_eff} + {2'b00, pending_q};
    issue       = (state_q == StRun) && (issued_q != len_q) && (credit_used < 3'd2);
    fifo_wdata  = '{re: rom_re_data, im: rom_im_data, index: pend_index_q, last: pend_last_q};

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (len_clamp == '0) ? StDone : StRun;
      StRun:   if (issued_q == len_q) state_d = StDrain;
      StDrain: if (pop && fifo_rdata.last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      issued_q     <= '0;
      next_addr_q  <= '0;
      rom_addr_q   <= '0;
      pending_q    <= 1'b0;
      pend_index_q <= '0;
      pend_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= issue;
      if (state_q == StIdle && start) begin
        len_q       <= len_clamp;
        next_addr_q <= base_mod;
        issued_q    <= '0;
      end
      if (issue) begin
        rom_addr_q   <= next_addr_q;
        next_addr_q  <= tw_addr_inc(next_addr_q);
        issued_q     <= issued_q + 1'b1;
        pend_index_q <= issued_q;
        pend_last_q  <= ((issued_q + 1'b1) == len_q);
      end
    end
  end

  tw_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pending_q),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign busy        = (state_q == StRun) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign rom_addr    = rom_addr_q;
  assign tw.tw_valid = fifo_valid;
  assign tw.tw_re    = fifo_rdata.re;
  assign tw.tw_im    = fifo_rdata.im;
  assign tw.tw_index = fifo_rdata.index;
  assign tw.tw_last  = fifo_rdata.last;

endmodule

// File: tb/tb_fft_twiddle_fetch.sv
// Directed bench for fft_twiddle_fetch with a behavioural twiddle ROM and output monitor.
module tb_fft_twiddle_fetch;
  import fft_twiddle_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  base_addr = '0;
  logic [5:0]  length = '0;
  logic        busy, done;
  logic [4:0]  rom_addr;
  logic [15:0] rom_re_data, rom_im_data;
  logic [15:0] rom_re [32];
  logic [15:0] rom_im [32];

  fft_twiddle_fetch_if tw ();

  fft_twiddle_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .rom_addr    (rom_addr),
    .rom_re_data (rom_re_data),
    .rom_im_data (rom_im_data),
    .tw          (tw)
  );

  always #5 clk = ~clk;

  assign rom_re_data = rom_re[rom_addr];
  assign rom_im_data = rom_im[rom_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Output monitor: handshake log, stall stability, latency and done timing.
  int          cyc = 0;
  logic [38:0] got_q [$];
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_cyc = 0;
  int          first_valid_cyc = -1;
  logic        stall_prev = 1'b0;
  logic [39:0] word_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [39:0] w;
    w = {tw.tw_valid, tw.tw_re, tw.tw_im, tw.tw_index, tw.tw_last};
    if (rst_n && stall_prev) check("stall_hold", 64'(w), 64'(word_prev));
    stall_prev = rst_n && tw.tw_valid && !tw.tw_ready;
    word_prev  = w;
    if (rst_n && tw.tw_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (rst_n && tw.tw_valid && tw.tw_ready) begin
      got_q.push_back(w[38:0]);
      hs_cnt++;
      if (tw.tw_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [4:0] b, input logic [5:0] l, output int sc);
    got_q.delete();
    hs_cnt          = 0;
    first_valid_cyc = -1;
    base_addr       = b;
    length          = l;
    start           = 1'b1;
    tick();
    sc    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input logic [31:0] pat, input int limit);
    int d0 = done_cnt;
    int k  = 0;
    while (done_cnt == d0 && k < limit) begin
      tw.tw_ready = pat[k % 32];
      tick();
      k++;
    end
    if (done_cnt == d0) check("done_timeout", 64'(0), 64'(1));
    tw.tw_ready = 1'b1;
  endtask

  task automatic check_pairs(input string name, input logic [4:0] b, input int n);
    logic [4:0]  a;
    logic [38:0] exp;
    check({name, "_count"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      a   = 5'(((int'(b) % 28) + i) % 28);
      exp = {rom_re[a], rom_im[a], 6'(i), (i == n - 1)};
      check($sformatf("%s_pair%0d", name, i), 64'(got_q[i]), 64'(exp));
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_done"}, 64'(done), 64'(0));
    check({name, "_rom_addr"}, 64'(rom_addr), 64'(0));
    check({name, "_valid"}, 64'(tw.tw_valid), 64'(0));
    check({name, "_re"}, 64'(tw.tw_re), 64'(0));
    check({name, "_im"}, 64'(tw.tw_im), 64'(0));
    check({name, "_index"}, 64'(tw.tw_index), 64'(0));
    check({name, "_last"}, 64'(tw.tw_last), 64'(0));
  endtask

  logic [15:0] t1_im [8];
  logic [15:0] t3_im [4];

  initial begin
    int sc;
    int d0;
    int k;
    rom_im = '{16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'hFF00,
               16'h0000, 16'hFF4A, 16'hFF00, 16'hFF4A, 16'h0000, 16'hFF9E, 16'hFF4A, 16'hFF13,
               16'hFF00, 16'hFF03, 16'hFF0F, 16'hFF1D, 16'hFF2B, 16'hFF3C, 16'hFF4D, 16'hFF5D,
               16'hFF6A, 16'hFF71, 16'hFF87, 16'hFF7C, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 32; i++) rom_re[i] = 16'h0100 - 16'(7 * i);
    t1_im = '{16'h0000, 16'hFF00, 16'h0000, 16'hFF00, 16'h0000, 16'hFF4A, 16'hFF00, 16'hFF4A};
    t3_im = '{16'hFF87, 16'hFF7C, 16'h0000, 16'h0000};

    tw.tw_ready = 1'b0;
    rst_n       = 1'b0;
    repeat (3) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Streaming with ready held high.
    tw.tw_ready = 1'b1;
    launch(5'd4, 6'd8, sc);
    wait_done(32'hFFFF_FFFF, 100);
    check_pairs("t1", 5'd4, 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check($sformatf("t1_im%0d", i), 64'(got_q[i][22:7]), 64'(t1_im[i]));
    check("t1_first_valid_cyc", 64'(first_valid_cyc), 64'(sc + 2));
    check("t1_last_cyc", 64'(last_cyc), 64'(sc + 9));
    check("t1_done_cyc", 64'(done_cyc), 64'(last_cyc + 1));
    check("t1_busy_after", 64'(busy), 64'(0));

    // Backpressure with a fixed irregular ready pattern.
    launch(5'd16, 6'd12, sc);
    wait_done(32'b1011_0010_0110_1001_1100_0101_1010_0011, 200);
    check_pairs("t2", 5'd16, 12);
    if (got_q.size() == 12) begin
      check("t2_im_first", 64'(got_q[0][22:7]), 64'(16'hFF00));
      check("t2_im_last", 64'(got_q[11][22:7]), 64'(16'hFF7C));
    end
    check("t2_done_cyc", 64'(done_cyc), 64'(last_cyc + 1));

    // Address wrap at the ROM depth.
    launch(5'd26, 6'd4, sc);
    wait_done(32'hFFFF_FFFF, 100);
    check_pairs("t3", 5'd26, 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("t3_im%0d", i), 64'(got_q[i][22:7]), 64'(t3_im[i]));

    // Zero length: immediate done, nothing streamed.
    launch(5'd5, 6'd0, sc);
    wait_done(32'hFFFF_FFFF, 20);
    check("t4_len0_done_cyc", 64'(done_cyc), 64'(sc));
    check("t4_len0_hs", 64'(hs_cnt), 64'(0));
    check("t4_len0_valid_seen", 64'(first_valid_cyc >= 0), 64'(0));

    // Length clamp and out-of-range base.
    launch(5'd3, 6'd31, sc);
    wait_done(32'hFFFF_FFFF, 200);
    check_pairs("t4_clamp", 5'd3, 28);
    launch(5'd30, 6'd2, sc);
    wait_done(32'hFFFF_FFFF, 50);
    check_pairs("t4_basewrap", 5'd2, 2);

    // Reset in the middle of a range.
    launch(5'd10, 6'd8, sc);
    k = 0;
    while (hs_cnt < 3 && k < 50) begin
      tick();
      k++;
    end
    check("t5_reached3", 64'(hs_cnt >= 3), 64'(1));
    d0    = done_cnt;
    rst_n = 1'b0;
    tick();
    check_zero_outputs("t5_reset");
    rst_n = 1'b1;
    repeat (5) tick();
    check("t5_no_done", 64'(done_cnt), 64'(d0));
    check("t5_idle_valid", 64'(tw.tw_valid), 64'(0));
    launch(5'd0, 6'd2, sc);
    wait_done(32'hFFFF_FFFF, 50);
    check_pairs("t5_after", 5'd0, 2);

    // Start pulse while busy must be ignored.
    launch(5'd0, 6'd6, sc);
    tick();
    base_addr = 5'd9;
    length    = 6'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_done(32'hFFFF_FFFF, 100);
    repeat (5) tick();
    check_pairs("t6", 5'd0, 6);
    check("t6_busy_after", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
